// File: rtl/rv2t_decode_queue.sv
// rv2t_decode_queue: DEPTH-entry instruction buffer feeding a registered RV32 decode stage.
// Build option: define RV2T_MUL_DIV_EN to decode the M extension; otherwise MUL/DIV encodings are illegal.
module rv2t_decode_queue #(
    parameter int DEPTH       = 4,
    parameter int PC_BITWIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sync_reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              IR_in,
    input  logic [PC_BITWIDTH-1:0]   PC_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              IR_out,
    output logic [PC_BITWIDTH-1:0]   PC_out,
    output logic [4:0]               rs1,
    output logic [4:0]               rs2,
    output logic [4:0]               rd,
    output logic [11:0]              csr,
    output logic [19:0]              ctl_vec,
    output logic                     exception_illegal_instruction,
    output logic [$clog2(DEPTH):0]   fill_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam int EW = PC_BITWIDTH + 32;
    localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    localparam int C_X_RS1    = 0;
    localparam int C_Y_RS2    = 1;
    localparam int C_Y_IMM    = 2;
    localparam int C_SAVE_RD  = 3;
    localparam int C_ALU      = 4;
    localparam int C_MULDIV   = 5;
    localparam int C_LUI      = 6;
    localparam int C_AUIPC    = 7;
    localparam int C_JAL      = 8;
    localparam int C_JALR     = 9;
    localparam int C_BRANCH   = 10;
    localparam int C_LOAD     = 11;
    localparam int C_STORE    = 12;
    localparam int C_SYSTEM   = 13;
    localparam int C_CSR      = 14;
    localparam int C_CSR_WR   = 15;
    localparam int C_MISC_MEM = 16;
    localparam int C_MRET     = 17;
    localparam int C_WFI      = 18;
    localparam int C_Y_ST_OFF = 19;

    // Returns {illegal, ctl_vec}; an illegal encoding never leaks control bits.
    function automatic logic [20:0] f_decode(input logic [31:0] ir);
        logic [19:0] ctl;
        logic        ill;
        logic [2:0]  f3;
        ctl = 20'd0;
        ill = 1'b0;
        f3  = ir[14:12];
        if (ir[1:0] != 2'b11) begin
            ill = 1'b1;
        end else begin
            case (ir[6:2])
                OPC_LUI: begin
                    ctl[C_LUI]     = 1'b1;
                    ctl[C_SAVE_RD] = 1'b1;
                end
                OPC_AUIPC: begin
                    ctl[C_AUIPC]   = 1'b1;
                    ctl[C_SAVE_RD] = 1'b1;
                end
                OPC_JAL: begin
                    ctl[C_JAL]     = 1'b1;
                    ctl[C_SAVE_RD] = 1'b1;
                end
                OPC_JALR: begin
                    ctl[C_JALR]    = 1'b1;
                    ctl[C_X_RS1]   = 1'b1;
                    ctl[C_SAVE_RD] = 1'b1;
                end
                OPC_BRANCH: begin
                    ctl[C_BRANCH]  = 1'b1;
                    ctl[C_X_RS1]   = 1'b1;
                    ctl[C_Y_RS2]   = 1'b1;
                end
                OPC_LOAD: begin
                    ctl[C_LOAD]    = 1'b1;
                    ctl[C_X_RS1]   = 1'b1;
                    ctl[C_Y_IMM]   = 1'b1;
                    ctl[C_SAVE_RD] = 1'b1;
                end
                OPC_STORE: begin
                    ctl[C_STORE]    = 1'b1;
                    ctl[C_X_RS1]    = 1'b1;
                    ctl[C_Y_RS2]    = 1'b1;
                    ctl[C_Y_ST_OFF] = 1'b1;
                end
                OPC_OP_IMM: begin
                    ctl[C_X_RS1]   = 1'b1;
                    ctl[C_Y_IMM]   = 1'b1;
                    ctl[C_SAVE_RD] = 1'b1;
                    ctl[C_ALU]     = 1'b1;
                end
                OPC_OP: begin
                    ctl[C_X_RS1]   = 1'b1;
                    ctl[C_Y_RS2]   = 1'b1;
                    ctl[C_SAVE_RD] = 1'b1;
                    if (ir[25] == 1'b0) begin
                        ctl[C_ALU] = 1'b1;
`ifdef RV2T_MUL_DIV_EN
                    end else begin
                        ctl[C_MULDIV] = 1'b1;
                    end
`else
                    end else if (ir[31:25] == 7'b0000001) begin
                        ill = 1'b1;
                    end else begin
                        ctl[C_MULDIV] = 1'b1;
                    end
`endif
                end
                OPC_SYSTEM: begin
                    ctl[C_SYSTEM] = 1'b1;
                    if ((f3 == 3'b000) && (ir[24:20] == 5'b00010)) begin
                        ctl[C_MRET] = 1'b1;
                    end else if ((f3 == 3'b000) && (ir[24:20] == 5'b00101)) begin
                        ctl[C_WFI] = 1'b1;
                    end else begin
                        ctl[C_CSR]     = |f3;
                        ctl[C_SAVE_RD] = |f3;
                        ctl[C_CSR_WR]  = |ir[19:15];
                    end
                end
                OPC_MISC_MEM: begin
                    // FENCE is a no-op here; only FENCE.I needs the pipeline's attention
                    if (f3 == 3'b001) begin
                        ctl[C_MISC_MEM] = 1'b1;
                    end else if (f3 == 3'b000) begin
                        ctl = 20'd0;
                    end else begin
                        ill = 1'b1;
                    end
                end
                default: ill = 1'b1;
            endcase
        end
        return ill ? {1'b1, 20'd0} : {1'b0, ctl};
    endfunction

    logic [EW-1:0]          r_mem [DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [FW-1:0]          r_fill;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic [31:0]            r_ir;
    logic [PC_BITWIDTH-1:0] r_pc;
    logic [19:0]            r_ctl;
    logic                   r_ill;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_clear;
    logic [FW-1:0]          w_fill_nxt;
    logic [EW-1:0]          w_rd_entry;
    logic [20:0]            w_dec;

    assign w_clear    = flush | sync_reset;
    assign w_push     = in_valid & r_in_ready;
    assign w_pop      = (r_fill != {FW{1'b0}}) & (~r_out_valid | out_ready);
    assign w_rd_entry = r_mem[r_rd_ptr];
    assign w_dec      = f_decode(w_rd_entry[31:0]);

    // Occupancy after this edge's push/pop; a pop always needs a non-empty buffer.
    always_comb begin
        w_fill_nxt = r_fill;
        if (w_push && !w_pop) begin
            w_fill_nxt = r_fill + FW'(1);
        end else if (w_pop && !w_push) begin
            w_fill_nxt = r_fill - FW'(1);
        end else begin
            w_fill_nxt = r_fill;
        end
    end

    // Buffer storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push && !w_clear) begin
            r_mem[r_wr_ptr] <= {PC_in, IR_in};
        end else begin
            r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
        end
    end

    // Pointers, occupancy, ready and output-valid control.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr    <= {AW{1'b0}};
            r_rd_ptr    <= {AW{1'b0}};
            r_fill      <= {FW{1'b0}};
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (w_clear) begin
            r_wr_ptr    <= {AW{1'b0}};
            r_rd_ptr    <= {AW{1'b0}};
            r_fill      <= {FW{1'b0}};
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + AW'(1);
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_rd_ptr    <= r_rd_ptr;
                r_out_valid <= 1'b0;
            end else begin
                r_rd_ptr    <= r_rd_ptr;
                r_out_valid <= r_out_valid;
            end
            r_fill     <= w_fill_nxt;
            r_in_ready <= (w_fill_nxt < FILL_MAX);
        end
    end

    // Output stage: captures the popped entry together with its decode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ir  <= 32'd0;
            r_pc  <= {PC_BITWIDTH{1'b0}};
            r_ctl <= 20'd0;
            r_ill <= 1'b0;
        end else if (w_pop && !w_clear) begin
            r_ir  <= w_rd_entry[31:0];
            r_pc  <= w_rd_entry[EW-1:32];
            r_ctl <= w_dec[19:0];
            r_ill <= w_dec[20];
        end else begin
            r_ir  <= r_ir;
            r_pc  <= r_pc;
            r_ctl <= r_ctl;
            r_ill <= r_ill;
        end
    end

    assign in_ready                      = r_in_ready;
    assign out_valid                     = r_out_valid;
    assign fill_level                    = r_fill;
    assign IR_out                        = r_ir;
    assign PC_out                        = r_pc;
    assign rs1                           = r_ir[19:15];
    assign rs2                           = r_ir[24:20];
    assign rd                            = r_ir[11:7];
    assign csr                           = r_ir[31:20];
    assign ctl_vec                       = r_ctl;
    assign exception_illegal_instruction = r_ill;

endmodule
